// File: rtl/booth_seq_mul_ctrl_if.sv
// Handshake, operand/result bus and Booth digit-select outputs of booth_seq_mul_ctrl.
// The master side offers operands and consumes the product; the slave side is the controller.
interface booth_seq_mul_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH/2)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               pp_zero;
  logic               pp_one;
  logic               pp_double;
  logic               pp_reverse;
  logic               pp_first;
  logic               pp_last;
  logic [CNT_W-1:0]   pp_index;

  modport master (
    output in_valid, multiplicand, multiplier, flush, out_ready,
    input  in_ready, out_valid, product, busy,
    input  pp_zero, pp_one, pp_double, pp_reverse, pp_first, pp_last, pp_index
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, flush, out_ready,
    output in_ready, out_valid, product, busy,
    output pp_zero, pp_one, pp_double, pp_reverse, pp_first, pp_last, pp_index
  );
endinterface

// File: rtl/booth_seq_mul_ctrl.sv
// Iterative radix-4 Booth multiplier controller: one Booth digit per cycle, emitting
// partial-product selects and accumulating the signed 2*WIDTH product.
module booth_seq_mul_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH/2)
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_seq_mul_ctrl_if.slave bus
);
  localparam int              PW         = 2*WIDTH;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(WIDTH/2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [PW-1:0]    acc, acc_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;

  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   b_shift;
  logic [CNT_W:0]   digit_base;
  logic [2:0]       triplet;
  logic             dig_zero, dig_one, dig_double, dig_reverse;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    pp_mag;
  logic [PW-1:0]    pp_signed;
  logic [PW-1:0]    pp_shifted;
  logic [PW-1:0]    acc_sum;
  logic             in_run;

  // Appending B[-1]=0 lets digit i read its triplet from bits [2i+2:2i] of b_ext.
  assign b_ext      = {b_reg, 1'b0};
  assign digit_base = {cnt, 1'b0};
  assign b_shift    = b_ext >> digit_base;
  assign triplet    = b_shift[2:0];

  always_comb begin
    dig_zero    = 1'b0;
    dig_one     = 1'b0;
    dig_double  = 1'b0;
    dig_reverse = 1'b0;
    case (triplet)
      3'b001, 3'b010: dig_one = 1'b1;
      3'b011:         dig_double = 1'b1;
      3'b100: begin
        dig_double  = 1'b1;
        dig_reverse = 1'b1;
      end
      3'b101, 3'b110: begin
        dig_one     = 1'b1;
        dig_reverse = 1'b1;
      end
      default:        dig_zero = 1'b1;
    endcase
  end

  // Sign-extend to the full product width first so that doubling or negating the
  // most-negative multiplicand cannot overflow.
  assign a_ext = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};

  always_comb begin
    pp_mag = '0;
    if (dig_one) begin
      pp_mag = a_ext;
    end else if (dig_double) begin
      pp_mag = a_ext << 1;
    end
    pp_signed = dig_reverse ? (~pp_mag + 1'b1) : pp_mag;
  end

  assign pp_shifted = pp_signed << digit_base;
  assign acc_sum    = acc + pp_shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      cnt   <= cnt_next;
      acc   <= acc_next;
      a_reg <= a_next;
      b_reg <= b_next;
    end
  end

  // Flush outranks both operand capture and product handoff.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    acc_next   = acc;
    a_next     = a_reg;
    b_next     = b_reg;
    case (state)
      IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          a_next     = bus.multiplicand;
          b_next     = bus.multiplier;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          cnt_next   = '0;
          acc_next   = '0;
          state_next = IDLE;
        end else begin
          acc_next = acc_sum;
          if (cnt == LAST_DIGIT) begin
            state_next = DONE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.flush) begin
          cnt_next   = '0;
          acc_next   = '0;
          state_next = IDLE;
        end else if (bus.out_ready) begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        acc_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign in_run = (state == RUN);

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state == RUN) || (state == DONE);
  assign bus.product    = (state == DONE) ? acc : '0;

  assign bus.pp_zero    = in_run && dig_zero;
  assign bus.pp_one     = in_run && dig_one;
  assign bus.pp_double  = in_run && dig_double;
  assign bus.pp_reverse = in_run && dig_reverse;
  assign bus.pp_first   = in_run && (cnt == '0);
  assign bus.pp_last    = in_run && (cnt == LAST_DIGIT);
  assign bus.pp_index   = in_run ? cnt : '0;
endmodule

// File: tb/tb_booth_seq_mul_ctrl.sv
// Directed bench for booth_seq_mul_ctrl (WIDTH=32): products, digit selects, backpressure,
// flush and asynchronous reset, with hand-computed expected values.
module tb_booth_seq_mul_ctrl;
  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  booth_seq_mul_ctrl_if #(.WIDTH(32)) bus ();

  booth_seq_mul_ctrl #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid     = valid;
    bus.multiplicand = a;
    bus.multiplier   = b;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] ppVec();
    return {bus.pp_zero, bus.pp_one, bus.pp_double, bus.pp_reverse, bus.pp_first, bus.pp_last,
            bus.busy};
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, "_product"}, bus.product, 64'd0);
    checkOutput({tag, "_pp_busy"}, 64'(ppVec()), 64'd0);
    checkOutput({tag, "_pp_index"}, 64'(bus.pp_index), 64'd0);
  endtask

  task automatic startOp(input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b1, a, b);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
  endtask

  // Entered one time unit after the capture edge; leaves the bench one unit after edge T+16.
  task automatic waitDone(input string tag, input logic [63:0] expected);
    int early;
    int ready_seen;
    early      = 0;
    ready_seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.out_valid) early++;
      if (bus.in_ready) ready_seen++;
      tick();
    end
    checkOutput({tag, "_early_valid"}, 64'(early), 64'd0);
    checkOutput({tag, "_ready_in_run"}, 64'(ready_seen), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    checkOutput({tag, "_product"}, bus.product, expected);
  endtask

  task automatic finishOp(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkIdle({tag, "_after"});
  endtask

  initial begin
    logic [6:0] exp_pp;
    int         seen_valid;
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    #12;
    checkIdle("reset");
    rst_n = 1'b1;
    tick();

    $display("[TB] basic products");
    startOp(32'd3, 32'd5);
    waitDone("3x5", 64'h0000_0000_0000_000F);
    finishOp("3x5");

    startOp(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("m1xm1", 64'h0000_0000_0000_0001);
    finishOp("m1xm1");

    startOp(32'h8000_0000, 32'h8000_0000);
    waitDone("minxmin", 64'h4000_0000_0000_0000);
    finishOp("minxmin");

    startOp(32'h8000_0000, 32'h7FFF_FFFF);
    waitDone("minxmax", 64'hC000_0000_8000_0000);
    finishOp("minxmax");

    $display("[TB] digit selects for B=3");
    startOp(32'd5, 32'd3);
    for (int d = 0; d < 16; d++) begin
      // {zero, one, double, reverse, first, last, busy}
      if (d == 0)       exp_pp = 7'b0101101;
      else if (d == 1)  exp_pp = 7'b0100001;
      else if (d == 15) exp_pp = 7'b1000011;
      else              exp_pp = 7'b1000001;
      checkOutput($sformatf("digit%0d_pp", d), 64'(ppVec()), 64'(exp_pp));
      checkOutput($sformatf("digit%0d_index", d), 64'(bus.pp_index), 64'(d));
      tick();
    end
    checkOutput("b3_product", bus.product, 64'd15);
    checkOutput("b3_done_pp", 64'(ppVec()), 64'd1);
    finishOp("b3");

    $display("[TB] backpressure in DONE");
    startOp(32'hFFFF_FFF9, 32'd6);
    waitDone("m7x6", 64'hFFFF_FFFF_FFFF_FFD6);
    applyStimulus(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("hold%0d_valid", i), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("hold%0d_product", i), bus.product, 64'hFFFF_FFFF_FFFF_FFD6);
      checkOutput($sformatf("hold%0d_in_ready", i), 64'(bus.in_ready), 64'd0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    finishOp("hold");

    $display("[TB] flush");
    startOp(32'd3, 32'd5);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("flush_at_index", 64'(bus.pp_index), 64'd7);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checkIdle("flush_run");
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) seen_valid++;
      tick();
    end
    checkOutput("flush_no_output", 64'(seen_valid), 64'd0);

    bus.flush = 1'b1;
    applyStimulus(1'b1, 32'd9, 32'd9);
    tick();
    bus.flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkIdle("flush_idle_nocapture");

    startOp(32'd2, 32'hFFFF_FFFD);
    waitDone("2xm3", 64'hFFFF_FFFF_FFFF_FFFA);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    checkIdle("flush_done");

    $display("[TB] reset mid-run");
    startOp(32'd7, 32'd7);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("pre_reset_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #2;
    checkIdle("async_reset");
    rst_n = 1'b1;
    tick();
    startOp(32'd6, 32'hFFFF_FFF9);
    waitDone("6xm7", 64'hFFFF_FFFF_FFFF_FFD6);
    finishOp("6xm7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
